// File: rtl/tock_accumulator.sv
// Saturating 16-bit accumulator over PERIOD accepted 8-bit operand pairs,
// with valid/ready handshakes on both the input and the output side.
module tock_accumulator #(
    parameter int unsigned PERIOD = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_sat,
    output logic [7:0]  out_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam logic [7:0] PERIOD_CNT = 8'(PERIOD);

    // 17-bit sum so that a carry out of the 16-bit accumulator is visible.
    function automatic logic [16:0] add_pair(input logic [15:0] base,
                                             input logic [7:0]  a,
                                             input logic [7:0]  b);
        return {1'b0, base} + {9'd0, a} + {9'd0, b};
    endfunction

    state_t      state_r;
    logic [15:0] acc_r;
    logic        sat_r;
    logic [7:0]  cnt_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [15:0] out_sum_r;
    logic        out_sat_r;
    logic [7:0]  out_count_r;

    logic [15:0] base_acc_s;
    logic        base_sat_s;
    logic [16:0] sum_s;
    logic [15:0] acc_next_s;
    logic        sat_next_s;
    logic [7:0]  cnt_next_s;
    logic        accept_s;
    logic        last_s;

    // Next accumulator/flag/count values for an accept in the current state.
    always_comb begin
        base_acc_s = 16'd0;
        base_sat_s = 1'b0;
        cnt_next_s = 8'd1;
        if (state_r == ACCUM) begin
            base_acc_s = acc_r;
            base_sat_s = sat_r;
            cnt_next_s = cnt_r + 8'd1;
        end else begin
            base_acc_s = 16'd0;
            base_sat_s = 1'b0;
            cnt_next_s = 8'd1;
        end
        sum_s = add_pair(base_acc_s, in_a, in_b);
        if (sum_s[16]) begin
            acc_next_s = 16'hFFFF;
            sat_next_s = 1'b1;
        end else begin
            acc_next_s = sum_s[15:0];
            sat_next_s = base_sat_s;
        end
        accept_s = in_valid & in_ready_r;
        last_s   = (cnt_next_s == PERIOD_CNT);
    end

    // Control FSM; all outputs are registered and updated on state changes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            acc_r       <= 16'd0;
            sat_r       <= 1'b0;
            cnt_r       <= 8'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sum_r   <= 16'd0;
            out_sat_r   <= 1'b0;
            out_count_r <= 8'd0;
        end else begin
            case (state_r)
                IDLE, ACCUM: begin
                    if (accept_s) begin
                        acc_r <= acc_next_s;
                        sat_r <= sat_next_s;
                        cnt_r <= cnt_next_s;
                        if (last_s) begin
                            state_r     <= EMIT;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_sum_r   <= acc_next_s;
                            out_sat_r   <= sat_next_s;
                        end else begin
                            state_r <= ACCUM;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        out_sum_r   <= 16'd0;
                        out_sat_r   <= 1'b0;
                        out_count_r <= out_count_r + 8'd1;
                    end else begin
                        state_r <= EMIT;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    acc_r       <= 16'd0;
                    sat_r       <= 1'b0;
                    cnt_r       <= 8'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    out_sum_r   <= 16'd0;
                    out_sat_r   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_sat   = out_sat_r;
    assign out_count = out_count_r;

endmodule

// File: tb/tb_tock_accumulator.sv
// Self-checking bench: three instances (PERIOD 4, 200, 1) against a
// transaction-level reference model of the accumulate/emit behaviour.
module tb_tock_accumulator;

    localparam int PER [3] = '{4, 200, 1};

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid  [3];
    logic        out_ready [3];
    logic [7:0]  in_a      [3];
    logic [7:0]  in_b      [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic [15:0] out_sum   [3];
    logic        out_sat   [3];
    logic [7:0]  out_count [3];

    int vectors     = 0;
    int miscompares = 0;

    // Model: pairs counted and summed exactly; a period's result is the
    // true total clamped to 16 bits, flagged when the clamp was needed.
    bit          m_pend [3];
    int          m_n    [3];
    int          m_tot  [3];
    logic [15:0] m_sum  [3];
    bit          m_sat  [3];
    logic [7:0]  m_cnt  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tock_accumulator #(.PERIOD((g == 0) ? 4 : ((g == 1) ? 200 : 1))) dut (
            .clock    (clock),
            .reset    (reset),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_a     (in_a[g]),
            .in_b     (in_b[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_sum  (out_sum[g]),
            .out_sat  (out_sat[g]),
            .out_count(out_count[g])
        );
    end

    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_pend[k] <= 1'b0;
                m_n[k]    <= 0;
                m_tot[k]  <= 0;
                m_sum[k]  <= 16'd0;
                m_sat[k]  <= 1'b0;
                m_cnt[k]  <= 8'd0;
            end else if (m_pend[k]) begin
                if (out_ready[k]) begin
                    m_pend[k] <= 1'b0;
                    m_cnt[k]  <= m_cnt[k] + 8'd1;
                end
            end else if (in_valid[k]) begin
                if (m_n[k] + 1 == PER[k]) begin
                    m_pend[k] <= 1'b1;
                    m_sum[k]  <= (m_tot[k] + int'(in_a[k]) + int'(in_b[k]) > 65535) ? 16'hFFFF
                                 : 16'(m_tot[k] + int'(in_a[k]) + int'(in_b[k]));
                    m_sat[k]  <= (m_tot[k] + int'(in_a[k]) + int'(in_b[k]) > 65535);
                    m_n[k]    <= 0;
                    m_tot[k]  <= 0;
                end else begin
                    m_n[k]   <= m_n[k] + 1;
                    m_tot[k] <= m_tot[k] + int'(in_a[k]) + int'(in_b[k]);
                end
            end
        end
    end

    task automatic drive(input int k, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic r);
        in_valid[k]  = v;
        in_a[k]      = a;
        in_b[k]      = b;
        out_ready[k] = r;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || out_sum[k] !== 16'd0 ||
                out_sat[k] !== 1'b0 || out_count[k] !== 8'd0) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: got rdy=%b vld=%b sum=%0d sat=%b cnt=%0d want 1 0 0 0 0",
                         k, in_ready[k], out_valid[k], out_sum[k], out_sat[k], out_count[k]);
            end
        end
    endtask

    task automatic test_period1_wrap();
        drive(2, 1'b1, 8'd10, 8'd20, 1'b0);
        @(negedge clock);
        vectors++;
        if (out_valid[2] !== 1'b1 || out_sum[2] !== 16'd30) begin
            miscompares++;
            $display("FAIL p1_sum: got vld=%b sum=%0d want 1 30", out_valid[2], out_sum[2]);
        end
        for (int i = 0; i < 511; i++) begin
            drive(2, 1'b1, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'b1);
            @(negedge clock);
            vectors++;
            if (out_valid[2] !== m_pend[2] || in_ready[2] !== !m_pend[2] ||
                out_sum[2] !== (m_pend[2] ? m_sum[2] : 16'd0) || out_count[2] !== m_cnt[2]) begin
                miscompares++;
                $display("FAIL p1_stream cycle %0d: got vld=%b sum=%0d cnt=%0d want %b %0d %0d", i,
                         out_valid[2], out_sum[2], out_count[2], m_pend[2],
                         m_pend[2] ? m_sum[2] : 16'd0, m_cnt[2]);
            end
        end
        vectors++;
        if (out_count[2] !== 8'd0 || out_valid[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL p1_wrap: got cnt=%0d vld=%b want 0 0", out_count[2], out_valid[2]);
        end
        drive(2, 1'b0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 8'd3, 8'd3, 1'b0);
            @(negedge clock);
            if (i < 3) begin
                vectors++;
                if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL basic_early %0d: got vld=%b rdy=%b want 0 1", i, out_valid[0], in_ready[0]);
                end
            end
        end
        vectors++;
        if (out_valid[0] !== 1'b1 || out_sum[0] !== 16'd24 || out_sat[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_sum: got vld=%b sum=%0d sat=%b rdy=%b want 1 24 0 0",
                     out_valid[0], out_sum[0], out_sat[0], in_ready[0]);
        end
        drive(0, 1'b0, 8'd0, 8'd0, 1'b1);
        @(negedge clock);
        vectors++;
        if (out_count[0] !== 8'd1 || out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_sum[0] !== 16'd0) begin
            miscompares++;
            $display("FAIL basic_handoff: got cnt=%0d vld=%b rdy=%b sum=%0d want 1 0 1 0",
                     out_count[0], out_valid[0], in_ready[0], out_sum[0]);
        end
        drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 200; i++) begin
            drive(1, 1'b1, 8'd255, 8'd255, 1'b0);
            @(negedge clock);
        end
        vectors++;
        if (out_valid[1] !== 1'b1 || out_sum[1] !== 16'hFFFF || out_sat[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_sum: got vld=%b sum=%h sat=%b want 1 ffff 1", out_valid[1], out_sum[1], out_sat[1]);
        end
        drive(1, 1'b0, 8'd0, 8'd0, 1'b1);
        @(negedge clock);
        for (int i = 0; i < 200; i++) begin
            drive(1, 1'b1, 8'd1, 8'd1, 1'b0);
            @(negedge clock);
        end
        vectors++;
        if (out_valid[1] !== 1'b1 || out_sum[1] !== 16'd400 || out_sat[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_clear: got vld=%b sum=%0d sat=%b want 1 400 0", out_valid[1], out_sum[1], out_sat[1]);
        end
        drive(1, 1'b0, 8'd0, 8'd0, 1'b1);
        @(negedge clock);
        drive(1, 1'b0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic test_back_pressure();
        int          expect_sum;
        logic [7:0]  a;
        logic [7:0]  b;
        expect_sum = 0;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(255, 0));
            b = 8'($urandom_range(255, 0));
            expect_sum += int'(a) + int'(b);
            drive(0, 1'b1, a, b, 1'b0);
            @(negedge clock);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'b0);
            @(negedge clock);
            vectors++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_sum[0] !== 16'(expect_sum)) begin
                miscompares++;
                $display("FAIL bp_hold %0d: got vld=%b rdy=%b sum=%0d want 1 0 %0d",
                         i, out_valid[0], in_ready[0], out_sum[0], expect_sum);
            end
        end
        drive(0, 1'b1, 8'd2, 8'd2, 1'b1);
        @(negedge clock);
        vectors++;
        if (out_valid[0] !== 1'b0 || out_count[0] !== m_cnt[0]) begin
            miscompares++;
            $display("FAIL bp_release: got vld=%b cnt=%0d want 0 %0d", out_valid[0], out_count[0], m_cnt[0]);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 8'd2, 8'd2, 1'b0);
            @(negedge clock);
            vectors++;
            if (out_valid[0] !== (i == 3)) begin
                miscompares++;
                $display("FAIL bp_no_bypass %0d: got vld=%b want %b", i, out_valid[0], (i == 3));
            end
        end
        vectors++;
        if (out_sum[0] !== 16'd16) begin
            miscompares++;
            $display("FAIL bp_next_sum: got %0d want 16", out_sum[0]);
        end
        drive(0, 1'b0, 8'd0, 8'd0, 1'b1);
        @(negedge clock);
        drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 7; i++) begin
            drive(0, (i % 2) == 0, 8'd5, 8'd5, 1'b0);
            @(negedge clock);
            vectors++;
            if (out_valid[0] !== (i == 6)) begin
                miscompares++;
                $display("FAIL gap_valid %0d: got %b want %b", i, out_valid[0], (i == 6));
            end
        end
        vectors++;
        if (out_sum[0] !== 16'd40 || out_sat[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_sum: got sum=%0d sat=%b want 40 0", out_sum[0], out_sat[0]);
        end
        drive(0, 1'b0, 8'd0, 8'd0, 1'b1);
        @(negedge clock);
        drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1'b1, 8'd1, 8'd1, 1'b0);
            @(negedge clock);
        end
        drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_sum[0] !== 16'd0 || out_count[0] !== 8'd0) begin
            miscompares++;
            $display("FAIL rst_accum: got rdy=%b vld=%b sum=%0d cnt=%0d want 1 0 0 0",
                     in_ready[0], out_valid[0], out_sum[0], out_count[0]);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 8'd1, 8'd1, 1'b0);
            @(negedge clock);
        end
        vectors++;
        if (out_valid[0] !== 1'b1 || out_sum[0] !== 16'd8) begin
            miscompares++;
            $display("FAIL rst_fresh_sum: got vld=%b sum=%0d want 1 8", out_valid[0], out_sum[0]);
        end
        drive(0, 1'b0, 8'd0, 8'd0, 1'b1);
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 8'($urandom_range(255, 0)), 8'd7, 1'b0);
            @(negedge clock);
        end
        drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (out_valid[0] !== 1'b0 || out_sum[0] !== 16'd0 || out_count[0] !== 8'd0 || in_ready[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_emit: got vld=%b sum=%0d cnt=%0d rdy=%b want 0 0 0 1",
                     out_valid[0], out_sum[0], out_count[0], in_ready[0]);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(0, 1'($urandom_range(1, 0)), 8'($urandom_range(255, 0)),
                  8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
            @(negedge clock);
            vectors++;
            if (out_valid[0] !== m_pend[0] || in_ready[0] !== !m_pend[0] ||
                out_sum[0] !== (m_pend[0] ? m_sum[0] : 16'd0) ||
                out_sat[0] !== (m_pend[0] ? m_sat[0] : 1'b0) || out_count[0] !== m_cnt[0]) begin
                miscompares++;
                $display("FAIL random cycle %0d: got vld=%b sum=%0d sat=%b cnt=%0d want %b %0d %b %0d", i,
                         out_valid[0], out_sum[0], out_sat[0], out_count[0], m_pend[0],
                         m_pend[0] ? m_sum[0] : 16'd0, m_pend[0] ? m_sat[0] : 1'b0, m_cnt[0]);
            end
        end
        drive(0, 1'b0, 8'd0, 8'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(k, 1'b0, 8'd0, 8'd0, 1'b0);
        end
        repeat (2) @(negedge clock);
        test_reset();
        reset = 1'b0;
        @(negedge clock);
        test_period1_wrap();
        test_basic();
        test_saturation();
        test_back_pressure();
        test_gapped();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
